// File: rtl/window_conv3x3.sv
// 3x3 signed-kernel convolution over colour-cache windows.
// Three register stages: nine tap products, adder tree, shift + clamp.
// Includes a runtime-loadable kernel and an end-of-line pulse counter.

// One kernel tap: unsigned pixel times signed coefficient, registered.
module conv_tap #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int PROD_W = PIX_W + 1 + COEF_W
) (
    input  logic              clk,
    input  logic [PIX_W-1:0]  pix,
    input  logic [COEF_W-1:0] coef,
    output logic [PROD_W-1:0] prod
);
    logic signed [PROD_W-1:0] a, b;

    // Pixel is zero-extended, coefficient sign-extended; product always fits.
    assign a = signed'(PROD_W'(pix));
    assign b = PROD_W'($signed(coef));

    // S1 product register; data is qualified by the valid pipe, so no reset.
    always_ff @(posedge clk)
        prod <= a * b;
endmodule

module window_conv3x3 #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int LINE_W = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3*PIX_W-1:0] win_row0,
    input  logic [3*PIX_W-1:0] win_row1,
    input  logic [3*PIX_W-1:0] win_row2,
    input  logic [3:0]         norm_shift,
    input  logic               k_we,
    input  logic [3:0]         k_addr,
    input  logic [COEF_W-1:0]  k_data,
    output logic               out_valid,
    output logic [PIX_W-1:0]   pix_out,
    output logic               line_done,
    output logic               busy
);
    localparam int NTAP   = 9;
    localparam int STAGES = 3;
    localparam int PROD_W = PIX_W + 1 + COEF_W;
    localparam int SUM_W  = PROD_W + 4;            // nine terms need 4 guard bits
    localparam int CNT_W  = $clog2(LINE_W + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(LINE_W - 1);
    localparam logic signed [SUM_W-1:0] PIX_MAX  = SUM_W'((1 << PIX_W) - 1);

    logic [2:0][3*PIX_W-1:0]       rows;
    logic [NTAP-1:0][PIX_W-1:0]    pix;
    logic [NTAP-1:0][COEF_W-1:0]   kern;
    logic [NTAP-1:0][PROD_W-1:0]   prod;
    logic [STAGES:1]               vld_pipe;
    logic [3:0]                    sh1, sh2;
    logic signed [SUM_W-1:0]       sum_c, sum2, shd;
    logic [PIX_W-1:0]              pix_c;
    logic [CNT_W-1:0]              cnt;

    assign rows = {win_row2, win_row1, win_row0};

    // Tap index is row*3+col; col0 (oldest) sits in the top byte lane.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign pix[r*3+c] = rows[r][(2-c)*PIX_W +: PIX_W];
        end
    end

    for (genvar i = 0; i < NTAP; i++) begin : g_tap
        conv_tap #(.PIX_W(PIX_W), .COEF_W(COEF_W), .PROD_W(PROD_W)) u_tap (
            .clk  (clk),
            .pix  (pix[i]),
            .coef (kern[i]),
            .prod (prod[i])
        );
    end

    // Kernel store; identity after reset, out-of-range addresses dropped.
    // A window sampled on the write edge still sees the old coefficient.
    always_ff @(posedge clk) begin
        if (rst) begin
            kern    <= '0;
            kern[4] <= COEF_W'(1);
        end else if (k_we && k_addr < 4'(NTAP)) begin
            kern[k_addr] <= k_data;
        end
    end

    // Valid shift register: bit s is the valid flag of stage S<s>.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // Shift amount travels alongside its window.
    always_ff @(posedge clk) begin
        sh1 <= norm_shift;
        sh2 <= sh1;
    end

    // Adder tree over the nine sign-extended products.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NTAP; i++)
            sum_c = sum_c + SUM_W'($signed(prod[i]));
    end

    // S2 sum register.
    always_ff @(posedge clk)
        sum2 <= sum_c;

    assign shd = sum2 >>> sh2;

    // Clamp the normalised sum into the pixel range.
    always_comb begin
        pix_c = shd[PIX_W-1:0];
        if (shd < 0)            pix_c = '0;
        else if (shd > PIX_MAX) pix_c = '1;
    end

    // S3 output register; pix_out holds between valid outputs.
    always_ff @(posedge clk) begin
        if (rst)               pix_out <= '0;
        else if (vld_pipe[2])  pix_out <= pix_c;
    end

    // Line counter; pulses alongside the LINE_W-th output and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (vld_pipe[2]) begin
                if (cnt == CNT_LAST) begin
                    cnt       <= '0;
                    line_done <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign busy      = |vld_pipe;
endmodule

// File: tb/tb_window_conv3x3.sv
// Bench for window_conv3x3 (LINE_W=4): directed scenarios plus a randomized
// stream checked against an arithmetic model of the convolution.
module tb_window_conv3x3;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] win_row0 = '0, win_row1 = '0, win_row2 = '0;
    logic [3:0]  norm_shift = '0;
    logic        k_we = 1'b0;
    logic [3:0]  k_addr = '0;
    logic [7:0]  k_data = '0;
    logic        out_valid, line_done, busy;
    logic [7:0]  pix_out;

    int pass_cnt = 0;
    int total    = 0;
    int kref[9];

    window_conv3x3 #(.PIX_W(8), .COEF_W(8), .LINE_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .win_row0(win_row0), .win_row1(win_row1), .win_row2(win_row2),
        .norm_shift(norm_shift), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .out_valid(out_valid), .pix_out(pix_out), .line_done(line_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference: plain integer convolution, arithmetic shift, clamp to 0..255.
    function automatic logic [7:0] model(input logic [23:0] r0, input logic [23:0] r1,
                                         input logic [23:0] r2, input int sh);
        logic [23:0] rw[3];
        int sum, res;
        rw[0] = r0; rw[1] = r1; rw[2] = r2;
        sum = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                sum += int'(rw[r][8*(2-c) +: 8]) * kref[r*3+c];
        res = sum >>> sh;
        if (res < 0) return 8'h00;
        if (res > 255) return 8'hFF;
        return res[7:0];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; k_we = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) kref[i] = 0;
        kref[4] = 1;
    endtask

    task automatic kwrite(input int a, input int d);
        k_we = 1'b1; k_addr = 4'(a); k_data = 8'(d);
        cycle();
        k_we = 1'b0;
        if (a <= 8) kref[a] = d;
    endtask

    // Present one window, then wait (bounded) for its output.
    task automatic run_one(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                           input logic [3:0] sh, output logic [7:0] px, output int lat);
        win_row0 = a; win_row1 = b; win_row2 = c; norm_shift = sh; in_valid = 1'b1;
        lat = -1; px = '0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            in_valid = 1'b0;
            if (out_valid === 1'b1 && lat < 0) begin lat = i; px = pix_out; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (pix_out !== 8'h00) $display("FAIL reset_pix_out got %h want 00", pix_out); else pass_cnt++;
        total++; if (line_done !== 1'b0) $display("FAIL reset_line_done got %b want 0", line_done); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        in_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_identity();
        logic [7:0] px; int lat;
        do_reset();
        run_one(24'h102030, 24'h405060, 24'h708090, 4'd0, px, lat);
        total++; if (lat !== 3) $display("FAIL identity_latency got %0d want 3", lat); else pass_cnt++;
        total++; if (px !== 8'h50) $display("FAIL identity_pix got %h want 50", px); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL identity_single_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (pix_out !== 8'h50) $display("FAIL identity_hold got %h want 50", pix_out); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL identity_idle_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_box_blur();
        logic [7:0] px; int lat;
        do_reset();
        for (int i = 0; i < 9; i++) kwrite(i, 1);
        run_one(24'h080808, 24'h080808, 24'h080808, 4'd3, px, lat);
        total++; if (px !== 8'h09 || lat !== 3) $display("FAIL box_blur got %h lat %0d want 09 lat 3", px, lat); else pass_cnt++;
    endtask

    task automatic test_clamp();
        logic [7:0] px; int lat;
        do_reset();
        for (int i = 0; i < 9; i++) kwrite(i, 127);
        run_one(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 4'd0, px, lat);
        total++; if (px !== 8'hFF) $display("FAIL clamp_high got %h want FF", px); else pass_cnt++;
        for (int i = 0; i < 9; i++) kwrite(i, -128);
        run_one(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 4'd0, px, lat);
        total++; if (px !== 8'h00) $display("FAIL clamp_low got %h want 00", px); else pass_cnt++;
        do_reset();
        kwrite(4, -1);
        run_one(24'h000000, 24'h000500, 24'h000000, 4'd1, px, lat);
        total++; if (px !== 8'h00) $display("FAIL clamp_neg_shift got %h want 00", px); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        logic       bz[12];
        int first, last;
        do_reset();
        first = -1; last = -1;
        for (int c = 0; c < 12; c++) begin
            if (c < 5) begin
                in_valid = 1'b1; norm_shift = 4'($urandom_range(0, 3));
                win_row0 = 24'($urandom); win_row2 = 24'($urandom);
                win_row1 = {8'($urandom), 8'(c + 1), 8'($urandom)};
                norm_shift = 4'd0;
            end else in_valid = 1'b0;
            cycle();
            bz[c] = busy;
            if (out_valid === 1'b1) begin
                got.push_back(pix_out);
                if (first < 0) first = c;
                last = c;
            end
        end
        total++; if (got.size() != 5 || last - first != 4)
            $display("FAIL stream_count got %0d outputs over %0d cycles want 5 over 5", got.size(), last - first + 1); else pass_cnt++;
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            total++; if (got[i] !== 8'(i + 1)) $display("FAIL stream_pix[%0d] got %h want %h", i, got[i], 8'(i + 1)); else pass_cnt++;
        end
        total++; if (last < 0 || last + 1 >= 12 || bz[last] !== 1'b1 || bz[last+1] !== 1'b0)
            $display("FAIL stream_busy_drop last=%0d", last); else pass_cnt++;
    endtask

    task automatic test_line_done();
        logic [12:0] pat;
        int nout, pulses;
        logic expd;
        do_reset();
        pat = 13'b1101100111011;
        nout = 0; pulses = 0;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 13) ? pat[c] : 1'b0;
            win_row0 = 24'($urandom); win_row1 = 24'($urandom); win_row2 = 24'($urandom);
            cycle();
            if (line_done === 1'b1) pulses++;
            if (out_valid === 1'b1) begin
                nout++;
                expd = (nout % 4 == 0);
                total++; if (line_done !== expd) $display("FAIL line_done_out%0d got %b want %b", nout, line_done, expd); else pass_cnt++;
            end else begin
                total++; if (line_done !== 1'b0) $display("FAIL line_done_gap cycle %0d got %b want 0", c, line_done); else pass_cnt++;
            end
        end
        total++; if (nout != 9 || pulses != 2) $display("FAIL line_done_totals got %0d outs %0d pulses want 9 2", nout, pulses); else pass_cnt++;
    endtask

    task automatic test_hazards();
        logic [7:0] got[$];
        logic [7:0] px; int lat, nv;
        do_reset();
        win_row0 = 24'($urandom); win_row2 = 24'($urandom);
        win_row1 = {8'($urandom), 8'h10, 8'($urandom)}; norm_shift = 4'd0;
        in_valid = 1'b1; k_we = 1'b1; k_addr = 4'd4; k_data = 8'd2;
        cycle();
        k_we = 1'b0; kref[4] = 2;
        win_row1 = {8'($urandom), 8'h10, 8'($urandom)};
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) got.push_back(pix_out);
            cycle();
        end
        total++; if (got.size() != 2) $display("FAIL hazard_count got %0d want 2", got.size()); else pass_cnt++;
        if (got.size() == 2) begin
            total++; if (got[0] !== 8'h10) $display("FAIL hazard_old_coef got %h want 10", got[0]); else pass_cnt++;
            total++; if (got[1] !== 8'h20) $display("FAIL hazard_new_coef got %h want 20", got[1]); else pass_cnt++;
        end
        // Reset while two windows are in flight.
        in_valid = 1'b1; win_row1 = 24'h001100;
        cycle();
        win_row1 = 24'h002200;
        cycle();
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) kref[i] = 0;
        kref[4] = 1;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) nv++;
            cycle();
        end
        total++; if (nv != 0) $display("FAIL reset_flush got %0d busy/valid cycles want 0", nv); else pass_cnt++;
        run_one(24'h000000, 24'h003300, 24'h000000, 4'd0, px, lat);
        total++; if (px !== 8'h33) $display("FAIL reset_kernel_identity got %h want 33", px); else pass_cnt++;
        // rst and k_we together: reset wins.
        rst = 1'b1; k_we = 1'b1; k_addr = 4'd4; k_data = 8'd3;
        cycle();
        rst = 1'b0; k_we = 1'b0;
        run_one(24'h000000, 24'h002100, 24'h000000, 4'd0, px, lat);
        total++; if (px !== 8'h21) $display("FAIL rst_beats_kwe got %h want 21", px); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] e;
        int nchk;
        do_reset();
        nchk = 0;
        for (int c = 0; c < 410; c++) begin
            if (c < 400) begin
                in_valid = ($urandom_range(0, 9) < 7);
                win_row0 = 24'($urandom); win_row1 = 24'($urandom); win_row2 = 24'($urandom);
                norm_shift = 4'($urandom_range(0, 12));
                k_we = ($urandom_range(0, 4) == 0);
                k_addr = 4'($urandom_range(0, 15));
                k_data = 8'($urandom);
            end else begin
                in_valid = 1'b0; k_we = 1'b0;
            end
            if (in_valid) q.push_back(model(win_row0, win_row1, win_row2, int'(norm_shift)));
            cycle();
            if (k_we && k_addr <= 4'd8) kref[k_addr] = int'($signed(k_data));
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++; $display("FAIL random_unexpected_out cycle %0d pix %h", c, pix_out);
                end else begin
                    e = q.pop_front();
                    nchk++;
                    total++; if (pix_out !== e) $display("FAIL random_pix cycle %0d got %h want %h", c, pix_out, e); else pass_cnt++;
                end
            end
        end
        k_we = 1'b0;
        total++; if (q.size() != 0 || nchk < 100) $display("FAIL random_drain left %0d checked %0d", q.size(), nchk); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_box_blur();
        test_clamp();
        test_back_to_back();
        test_line_done();
        test_hazards();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
